// File: rtl/bus_arbiter.sv
// Purpose : round-robin arbiter/sequencer for the shared 32-bit datapath bus, with short bus locks.
// Latency : req sampled at edge k -> grant/Sout/dst_load valid for the cycle after edge k.
// Backpress: requesters hold req/req_src/req_dst until they see grant; losers simply wait.
//
// Ports:
//   clock, clear       - rising-edge clock, asynchronous active-high reset
//   req[NREQ]          - per-requester transfer request (level)
//   req_lock[NREQ]     - per-requester request to keep the bus for the next cycle
//   req_src[5*NREQ]    - 5-bit bus source code per requester (slice i = [5i+4:5i])
//   req_dst[NDST*NREQ] - destination load enables per requester
//   grant[NREQ]        - registered one-hot grant for the current transfer cycle
//   Sout[5]            - registered select code to the bus multiplexer
//   dst_load[NDST]     - registered destination load enables for the current transfer
//   bus_busy           - OR of grant
//   err_src            - one-cycle pulse when the granted source code is above 23
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int NDST     = 24,
  parameter int LOCK_MAX = 4,
  parameter int IDLE_SEL = 31
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_lock,
  input  logic [5*NREQ-1:0]      req_src,
  input  logic [NDST*NREQ-1:0]   req_dst,
  output logic [NREQ-1:0]        grant,
  output logic [4:0]             Sout,
  output logic [NDST-1:0]        dst_load,
  output logic                   bus_busy,
  output logic                   err_src
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  localparam logic [PTR_W-1:0] PTR_RESET     = PTR_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(LOCK_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [NREQ-1:0]  GRANT_ONE     = NREQ'(1);
  localparam logic [4:0]       IDLE_CODE     = 5'(IDLE_SEL);
  localparam logic [4:0]       MAX_VALID_SRC = 5'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;       // last granted requester; search starts just after it
  logic [CNT_W-1:0] lockCnt;   // continuation grants issued in the current lock

  // Per-requester views of the flattened source and destination buses.
  logic [4:0]      srcArr [NREQ];
  logic [NDST-1:0] dstArr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : gUnpack
      assign srcArr[gi] = req_src[5*gi +: 5];
      assign dstArr[gi] = req_dst[NDST*gi +: NDST];
    end
  endgenerate

  // Rotating priority search: first active requester at ptr+1, ptr+2, ... wrapping.
  // The last candidate examined is ptr itself, so the previous holder re-wins only
  // when nobody else is requesting.
  logic             arbFound;
  logic [PTR_W-1:0] arbIdx;
  logic [PTR_W-1:0] candIdx;
  int               cand;

  always_comb begin
    arbFound = 1'b0;
    arbIdx   = '0;
    cand     = 0;
    candIdx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      candIdx = PTR_W'(cand);
      if (!arbFound && req[candIdx]) begin
        arbFound = 1'b1;
        arbIdx   = candIdx;
      end
    end
  end

  // Continuation of a lock: the holder (ptr) keeps the bus without arbitration
  // until it has had LOCK_MAX consecutive grants.
  logic holdLock;
  assign holdLock = (state != IDLE) && req[ptr] && req_lock[ptr] && (lockCnt < CNT_LAST);

  logic [PTR_W-1:0] selIdx;
  logic             selValid;
  logic [4:0]       selSrc;
  logic             selBad;

  assign selIdx   = holdLock ? ptr : arbIdx;
  assign selValid = holdLock | arbFound;
  assign selSrc   = srcArr[selIdx];
  assign selBad   = (selSrc > MAX_VALID_SRC);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      ptr      <= PTR_RESET;
      lockCnt  <= '0;
      grant    <= '0;
      Sout     <= IDLE_CODE;
      dst_load <= '0;
      err_src  <= 1'b0;
    end else begin
      // State and bookkeeping.
      if (holdLock) begin
        state   <= LOCK;
        lockCnt <= lockCnt + CNT_ONE;
      end else if (arbFound) begin
        state   <= XFER;
        lockCnt <= '0;
        ptr     <= arbIdx;
      end else begin
        state   <= IDLE;
        lockCnt <= '0;
      end

      // Registered bus controls for the coming transfer cycle. An out-of-range
      // source still consumes the grant (so the pointer moves on) but the bus
      // is parked on the idle code and nothing is loaded.
      if (selValid) begin
        grant    <= GRANT_ONE << selIdx;
        Sout     <= selBad ? IDLE_CODE : selSrc;
        dst_load <= selBad ? '0 : dstArr[selIdx];
        err_src  <= selBad;
      end else begin
        grant    <= '0;
        Sout     <= IDLE_CODE;
        dst_load <= '0;
        err_src  <= 1'b0;
      end
    end
  end

  assign bus_busy = |grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Purpose : directed self-checking bench for bus_arbiter (NREQ=4, NDST=24, LOCK_MAX=4).
// Latency : outputs checked 1 time unit after each rising edge.
// Backpress: requesters modelled as holding req until granted.
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        clear;
  logic [3:0]  req;
  logic [3:0]  reqLock;
  logic [19:0] reqSrc;
  logic [95:0] reqDst;
  logic [3:0]  grant;
  logic [4:0]  sOut;
  logic [23:0] dstLoad;
  logic        busBusy;
  logic        errSrc;

  int nVec = 0;
  int nErr = 0;

  logic [23:0] dstVal [4];

  always #5 clock = ~clock;

  bus_arbiter #(
    .NREQ(4), .NDST(24), .LOCK_MAX(4), .IDLE_SEL(31)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .req      (req),
    .req_lock (reqLock),
    .req_src  (reqSrc),
    .req_dst  (reqDst),
    .grant    (grant),
    .Sout     (sOut),
    .dst_load (dstLoad),
    .bus_busy (busBusy),
    .err_src  (errSrc)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOut(input string tag, input logic [3:0] expGrant, input logic [4:0] expSout,
                          input logic [23:0] expDst, input logic expErr);
    checkEq({tag, ".grant"}, 32'(grant), 32'(expGrant));
    checkEq({tag, ".Sout"}, 32'(sOut), 32'(expSout));
    checkEq({tag, ".dst_load"}, 32'(dstLoad), 32'(expDst));
    checkEq({tag, ".bus_busy"}, 32'(busBusy), 32'(|expGrant));
    checkEq({tag, ".err_src"}, 32'(errSrc), 32'(expErr));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic setSrc(input int i, input logic [4:0] code);
    reqSrc[5*i +: 5] = code;
  endtask

  task automatic setDst(input int i, input logic [23:0] d);
    reqDst[24*i +: 24] = d;
  endtask

  initial begin
    dstVal[0] = 24'h000011;
    dstVal[1] = 24'h000202;
    dstVal[2] = 24'h003000;
    dstVal[3] = 24'h400000;

    clear   = 1'b1;
    req     = 4'b1111;
    reqLock = 4'b0000;
    reqSrc  = '0;
    reqDst  = '0;
    for (int i = 0; i < 4; i++) begin
      setSrc(i, 5'(i + 1));
      setDst(i, dstVal[i]);
    end

    // Reset held while requests toggle around it.
    step();
    req = 4'b0000;
    step();
    req = 4'b1111;
    checkOut("reset", 4'b0000, 5'd31, 24'h0, 1'b0);

    // Release: round robin 0,1,2,3,0,1,2,3 with no idle cycle.
    clear = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      checkOut($sformatf("rr%0d", c), 4'b0001 << (c % 4), 5'((c % 4) + 1), dstVal[c % 4], 1'b0);
    end

    // Lock by requester 2: four grants, then forced release to requester 0.
    req     = 4'b0100;
    reqLock = 4'b0100;
    setSrc(2, 5'd16);
    setSrc(0, 5'd0);
    step();
    checkOut("lock0", 4'b0100, 5'd16, dstVal[2], 1'b0);
    req = 4'b0101;
    setSrc(2, 5'd17);
    for (int c = 1; c < 4; c++) begin
      step();
      checkOut($sformatf("lock%0d", c), 4'b0100, 5'd17, dstVal[2], 1'b0);
    end
    step();
    checkOut("lockrel", 4'b0001, 5'd0, dstVal[0], 1'b0);
    req     = 4'b0000;
    reqLock = 4'b0000;
    step();
    checkOut("idle1", 4'b0000, 5'd31, 24'h0, 1'b0);

    // Invalid source code on requester 1.
    req = 4'b0010;
    setSrc(1, 5'd25);
    setDst(1, 24'h000001);
    step();
    checkOut("badsrc", 4'b0010, 5'd31, 24'h0, 1'b1);
    req = 4'b0000;
    step();
    checkOut("badsrc_end", 4'b0000, 5'd31, 24'h0, 1'b0);

    // Clear during a lock, then the lock count must restart.
    req     = 4'b0100;
    reqLock = 4'b0100;
    setSrc(2, 5'd16);
    step();
    checkOut("cl_first", 4'b0100, 5'd16, dstVal[2], 1'b0);
    step();
    checkOut("cl_lock", 4'b0100, 5'd16, dstVal[2], 1'b0);
    #2;
    clear = 1'b1;
    #1;
    checkOut("cl_async", 4'b0000, 5'd31, 24'h0, 1'b0);
    step();
    checkOut("cl_held", 4'b0000, 5'd31, 24'h0, 1'b0);
    clear = 1'b0;
    step();
    checkOut("cl_g0", 4'b0100, 5'd16, dstVal[2], 1'b0);
    req = 4'b0101;
    for (int c = 1; c < 4; c++) begin
      step();
      checkOut($sformatf("cl_g%0d", c), 4'b0100, 5'd16, dstVal[2], 1'b0);
    end
    step();
    checkOut("cl_rel", 4'b0001, 5'd0, dstVal[0], 1'b0);

    // Single requester re-requesting every cycle, including source codes 23 and 24.
    req     = 4'b1000;
    reqLock = 4'b0000;
    setSrc(3, 5'd4);
    step();
    checkOut("rr3_a", 4'b1000, 5'd4, dstVal[3], 1'b0);
    setSrc(3, 5'd23);
    step();
    checkOut("rr3_b", 4'b1000, 5'd23, dstVal[3], 1'b0);
    setSrc(3, 5'd24);
    step();
    checkOut("rr3_c", 4'b1000, 5'd31, 24'h0, 1'b1);
    setSrc(3, 5'd12);
    step();
    checkOut("rr3_d", 4'b1000, 5'd12, dstVal[3], 1'b0);
    req = 4'b0000;
    step();
    checkOut("idle2", 4'b0000, 5'd31, 24'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
